// File: rtl/regfile_dump.sv
// MIPS general-purpose register file with same-cycle write bypass on both read ports,
// plus a debug dump engine that streams every register in address order over valid/ready.
module regfile_dump #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_regwrite,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_writedata,
    input  logic [ADDR_WIDTH-1:0] i_rs,
    input  logic [ADDR_WIDTH-1:0] i_rt,
    output logic [DATA_WIDTH-1:0] o_regA,
    output logic [DATA_WIDTH-1:0] o_regB,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [DATA_WIDTH-1:0] o_dump_data,
    output logic [ADDR_WIDTH-1:0] o_dump_addr,
    output logic                  o_dump_last,
    output logic                  o_busy
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   dump_addr_q, dump_addr_d;
    logic [DATA_WIDTH-1:0]   dump_data_q, dump_data_d;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   load_addr;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    handshake;

    function automatic logic [DATA_WIDTH-1:0] bypass(input logic [ADDR_WIDTH-1:0] a);
        if ((ZERO_REG != 0) && (a == '0)) begin
            return '0;
        end else if (i_regwrite && (i_wr_addr == a)) begin
            return i_writedata;
        end else begin
            return regs[a];
        end
    endfunction

    assign wr_en  = i_regwrite && !((ZERO_REG != 0) && (i_wr_addr == '0));
    assign o_regA = bypass(i_rs);
    assign o_regB = bypass(i_rt);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[i_wr_addr] <= i_writedata;
        end
    end

    // The next beat is always either register 0 (fresh start) or the one after the current beat.
    assign load_addr = (state_q == StIdle) ? '0 : dump_addr_q + ADDR_WIDTH'(1);
    assign load_data = bypass(load_addr);
    assign handshake = (state_q == StSend) && i_dump_ready;

    always_comb begin
        state_d     = state_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        unique case (state_q)
            StIdle: begin
                if (i_dump_start) begin
                    dump_addr_d = load_addr;
                    dump_data_d = load_data;
                    state_d     = StSend;
                end
            end
            StSend: begin
                if (handshake) begin
                    if (dump_addr_q == LAST_ADDR) begin
                        state_d = StIdle;
                    end else begin
                        dump_addr_d = load_addr;
                        dump_data_d = load_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= StIdle;
            dump_addr_q <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
        end
    end

    assign o_dump_valid = (state_q == StSend);
    assign o_busy       = (state_q == StSend);
    assign o_dump_addr  = dump_addr_q;
    assign o_dump_data  = dump_data_q;
    assign o_dump_last  = o_dump_valid && (dump_addr_q == LAST_ADDR);

endmodule

// File: tb/tb_regfile_dump.sv
// Randomised bench for regfile_dump: array reference model for the read/write ports and a
// scoreboard queue of expected dump beats drained by an independent negedge monitor.
module tb_regfile_dump;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          regwrite;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] writedata;
    logic [AW-1:0] rs, rt;
    logic [DW-1:0] reg_a, reg_b;
    logic          dump_start, dump_ready;
    logic          dump_valid, dump_last, busy;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_addr;

    logic [DW-1:0] reg_a_n, reg_b_n, dump_data_n;
    logic [AW-1:0] dump_addr_n;
    logic          dump_valid_n, dump_last_n, busy_n;

    always #5 clk = ~clk;

    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1)) dut (
        .i_clock(clk), .i_reset(rst), .i_regwrite(regwrite), .i_wr_addr(wr_addr),
        .i_writedata(writedata), .i_rs(rs), .i_rt(rt), .o_regA(reg_a), .o_regB(reg_b),
        .i_dump_start(dump_start), .i_dump_ready(dump_ready), .o_dump_valid(dump_valid),
        .o_dump_data(dump_data), .o_dump_addr(dump_addr), .o_dump_last(dump_last),
        .o_busy(busy)
    );

    // Second instance with a writable register 0; only its read ports are checked.
    regfile_dump #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(0)) dut_nz (
        .i_clock(clk), .i_reset(rst), .i_regwrite(regwrite), .i_wr_addr(wr_addr),
        .i_writedata(writedata), .i_rs(rs), .i_rt(rt), .o_regA(reg_a_n), .o_regB(reg_b_n),
        .i_dump_start(1'b0), .i_dump_ready(1'b1), .o_dump_valid(dump_valid_n),
        .o_dump_data(dump_data_n), .o_dump_addr(dump_addr_n), .o_dump_last(dump_last_n),
        .o_busy(busy_n)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q [$];
    logic [DW-1:0] model_z [NR];
    logic [DW-1:0] model_n [NR];
    int            checks = 0;
    int            errors = 0;
    int            beats_seen = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input bit zr, input logic [AW-1:0] a);
        if (zr && a == 0) return '0;
        if (regwrite && wr_addr == a) return writedata;
        return zr ? model_z[a] : model_n[a];
    endfunction

    // Advance one clock, committing the inputs of the ending cycle into the models.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                model_z[i] = '0;
                model_n[i] = '0;
            end
        end else if (regwrite) begin
            model_n[wr_addr] = writedata;
            if (wr_addr != 0) model_z[wr_addr] = writedata;
        end
        #1;
    endtask

    // Expected beats are the register contents at start; ovr_addr models a write that lands
    // on that beat's loading edge.
    task automatic push_dump(input int ovr_addr, input logic [DW-1:0] ovr_data);
        beat_t b;
        for (int i = 0; i < NR; i++) begin
            b.addr = AW'(i);
            b.data = (i == ovr_addr) ? ovr_data : model_z[i];
            exp_q.push_back(b);
        end
    endtask

    task automatic check_all_zero(input string tag);
        regwrite = 1'b0;
        for (int a = 0; a < NR; a++) begin
            rs = AW'(a);
            rt = AW'(NR - 1 - a);
            #1;
            check({tag, "_regA"}, reg_a, '0);
            check({tag, "_regB"}, reg_b, '0);
        end
    endtask

    // mode 0: random ready; mode 1: ready pattern 1,0,0,1 with r3 overwritten while beat 3 stalls.
    task automatic run_dump(input int mode, input string tag);
        int  b0;
        int  cyc;
        bit  wrote;
        bit  pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        b0 = beats_seen;
        cyc = 0;
        wrote = 0;
        push_dump(-1, '0);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        while (beats_seen - b0 < NR && cyc < 1000) begin
            regwrite = 1'b0;
            dump_ready = (mode == 0) ? 1'($urandom_range(0, 1)) : pat[cyc % 4];
            if (mode == 1 && !wrote && dump_valid && dump_addr == 3 && !dump_ready) begin
                regwrite  = 1'b1;
                wr_addr   = 3;
                writedata = 32'h0000_00AA;
                wrote     = 1;
            end
            cyc++;
            tick();
        end
        regwrite = 1'b0;
        check({tag, "_beats"}, DW'(beats_seen - b0), DW'(NR));
        check({tag, "_valid_after"}, DW'(dump_valid), '0);
        check({tag, "_queue_left"}, DW'(exp_q.size()), '0);
        if (mode == 1) begin
            check({tag, "_stall_write_seen"}, DW'(wrote), 1);
            rs = 3;
            #1;
            check({tag, "_r3_after"}, reg_a, 32'h0000_00AA);
        end
    endtask

    // Scoreboard monitor: pops on every handshake and checks stall stability and last flag.
    initial begin
        bit            prev_stall;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_data;
        beat_t         b;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!rst && dump_valid) begin
                if (prev_stall) begin
                    check("stall_addr", DW'(dump_addr), DW'(prev_addr));
                    check("stall_data", dump_data, prev_data);
                end
                check("last_flag", DW'(dump_last), DW'(dump_addr == AW'(NR - 1)));
                check("busy_flag", DW'(busy), 1);
                if (dump_ready) begin
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat addr %0d data %h required none",
                                 dump_addr, dump_data);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_addr", DW'(dump_addr), DW'(b.addr));
                        check("beat_data", dump_data, b.data);
                    end
                end
                prev_stall = !dump_ready;
                prev_addr  = dump_addr;
                prev_data  = dump_data;
            end else begin
                prev_stall = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        rst = 1'b1; regwrite = 1'b0; wr_addr = '0; writedata = '0; rs = '0; rt = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", DW'(dump_valid), '0);
        check("rst_busy", DW'(busy), '0);
        check("rst_last", DW'(dump_last), '0);
        check_all_zero("rst");

        // Same-cycle bypass, then storage.
        regwrite = 1'b1; wr_addr = 5; writedata = 32'hDEAD_BEEF; rs = 5;
        #1;
        check("bypass_same", reg_a, 32'hDEAD_BEEF);
        tick();
        regwrite = 1'b0;
        #1;
        check("bypass_stored", reg_a, 32'hDEAD_BEEF);

        // Register 0 behaviour on both instances.
        regwrite = 1'b1; wr_addr = 0; writedata = 32'h0000_1234; rs = 0;
        #1;
        check("zero_same", reg_a, '0);
        check("nz_r0_same", reg_a_n, 32'h0000_1234);
        tick();
        regwrite = 1'b0;
        #1;
        check("zero_next", reg_a, '0);
        check("nz_r0_next", reg_a_n, 32'h0000_1234);

        // Random traffic against the model.
        repeat (80) begin
            regwrite  = 1'($urandom_range(0, 1));
            wr_addr   = AW'($urandom);
            writedata = $urandom;
            rs        = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
            rt        = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
            #1;
            check("rand_regA", reg_a, ref_read(1, rs));
            check("rand_regB", reg_b, ref_read(1, rt));
            check("rand_nz_regA", reg_a_n, ref_read(0, rs));
            tick();
        end

        // regs[k] = k + 100.
        for (int k = 0; k < NR; k++) begin
            regwrite = 1'b1; wr_addr = AW'(k); writedata = DW'(k + 100);
            tick();
        end
        regwrite = 1'b0;

        // Full-rate dump; r1 written on its loading edge; starts mid-dump and on last beat.
        dump_ready = 1'b1;
        b0 = beats_seen;
        push_dump(1, 32'hCAFE_0001);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int c = 0; c < NR; c++) begin
            regwrite   = (c == 0);
            wr_addr    = 1;
            writedata  = 32'hCAFE_0001;
            dump_start = (c == 15 || c == NR - 1);
            tick();
        end
        dump_start = 1'b0;
        regwrite   = 1'b0;
        check("full_valid_low", DW'(dump_valid), '0);
        check("full_busy_low", DW'(busy), '0);
        check("full_beats", DW'(beats_seen - b0), DW'(NR));
        check("full_queue_left", DW'(exp_q.size()), '0);

        // Earliest restart (first idle cycle), random ready, then backpressure pattern.
        run_dump(0, "rand_ready");
        run_dump(1, "backpressure");

        // Reset during beat 10.
        dump_ready = 1'b1;
        b0 = beats_seen;
        push_dump(-1, '0);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (10) tick();
        check("pre_rst_addr", DW'(dump_addr), 10);
        rst = 1'b1;
        dump_ready = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("midrst_valid", DW'(dump_valid), '0);
        check("midrst_busy", DW'(busy), '0);
        check("midrst_beats", DW'(beats_seen - b0), 10);
        check_all_zero("midrst");
        dump_ready = 1'b1;
        repeat (5) tick();
        check("midrst_still_idle", DW'(dump_valid), '0);
        check("midrst_no_beats", DW'(beats_seen - b0), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
